eth_rx_pktbuf: RTL
==================

ETH_RX_PKTBUF -- requirements
Module: eth_rx_pktbuf

Interface
REQ-001 SHALL have parameter BANK_WORDS, default 128, meaning 32-bit words per packet bank (addresses 0..BANK_WORDS-1).
REQ-002 SHALL have parameter MAX_LEN, default 512, meaning largest accepted packet length in bytes.
REQ-003 CLK  input  1  single clock; all logic on posedge CLK.
REQ-004 RST  input  1  reset, asynchronous, active-low (0 = in reset).
REQ-005 WR_ADDR  input  10  receiver word address; bit 9 set = non-buffer access, bits 6:0 = word index.
REQ-006 WR_DATA  input  32  receive word.
REQ-007 WR_STROBE  input  1  one-cycle write pulse.
REQ-008 PKT_DONE  input  1  one-cycle end-of-packet pulse.
REQ-009 PKT_GOOD  input  1  CRC/framing good, sampled with PKT_DONE.
REQ-010 PKT_LEN  input  16  packet length in bytes, sampled with PKT_DONE.
REQ-011 DESC_VALID  output  1  head descriptor available.
REQ-012 DESC_BANK  output  1  bank index of head packet.
REQ-013 DESC_LEN  output  16  byte length of head packet.
REQ-014 DESC_POP  input  1  consumer done with head; frees its bank.
REQ-015 RD_EN  input  1  read request into head bank.
REQ-016 RD_ADDR  input  7  word index for read.
REQ-017 RD_DATA  output  32  read word, valid the cycle after RD_EN.
REQ-018 DROP_CNT  output  16  count of discarded packets.

Function
REQ-019 Two banks SHALL each hold state FREE, FILLING or FULL; writer pointer wr_bank, head pointer rd_bank.
REQ-020 WR_STROBE with WR_ADDR[9]=0 and wr_bank FILLING SHALL write WR_DATA to wr_bank[WR_ADDR[6:0]]; WR_ADDR[9]=1 SHALL be ignored.
REQ-021 WR_STROBE while wr_bank is not FILLING SHALL discard the word and set the per-packet drop flag.
REQ-022 PKT_DONE with PKT_GOOD=1, PKT_LEN<=MAX_LEN, drop flag clear, wr_bank FILLING SHALL mark wr_bank FULL, store PKT_LEN, toggle wr_bank next cycle.
REQ-023 Any other PKT_DONE SHALL leave the bank FILLING (reused), increment DROP_CNT, clear drop flag.
REQ-024 After toggle, new wr_bank SHALL become FILLING if FREE, else stay FULL and further writes follow REQ-021.
REQ-025 DESC_VALID SHALL be 1 iff rd_bank is FULL; DESC_BANK=rd_bank; DESC_LEN=stored length of rd_bank.
REQ-026 DESC_POP with DESC_VALID=1 SHALL set rd_bank FREE and toggle rd_bank; DESC_POP with DESC_VALID=0 SHALL be ignored.
REQ-027 A bank freed by DESC_POP that equals a waiting wr_bank SHALL become FILLING the same cycle it is freed.
REQ-028 Simultaneous PKT_DONE and DESC_POP SHALL both take effect; pop is evaluated first.
REQ-029 Simultaneous WR_STROBE and PKT_DONE SHALL write the word into the finishing packet before commit.
REQ-030 RD_DATA SHALL have 1-cycle latency from rd_bank; RD_EN=0 SHALL hold RD_DATA.
REQ-031 Packets SHALL be delivered in arrival order; DROP_CNT SHALL saturate at 16'hffff.

Reset
REQ-032 RST=0 SHALL asynchronously set bank0 FILLING, bank1 FREE, wr_bank=0, rd_bank=0, drop flag 0.
REQ-033 In reset DESC_VALID=0, DESC_BANK=0, DESC_LEN=0, RD_DATA=0, DROP_CNT=0; buffer RAM contents undefined.
REQ-034 Reset mid-packet SHALL discard partial and stored packets without incrementing DROP_CNT.

Configuration
REQ-035 Macro ETH_RX_PKTBUF_DROPCNT_EN defined SHALL implement DROP_CNT per REQ-023/031.
REQ-036 Without ETH_RX_PKTBUF_DROPCNT_EN, DROP_CNT SHALL be constant 0 and no counter register built; drop behaviour unchanged.

Structure
REQ-037 Bank state encodings (FREE=2'd0, FILLING=2'd1, FULL=2'd2) and BANK_WORDS/MAX_LEN defaults SHALL live in the shared package.
REQ-038 Buffer storage SHALL be one sub-module eth_rx_pktbuf_ram: 256x32, one write port, one registered read port, address {bank,index}.

Verification
REQ-039 Write 8 words 0x12345678.. to bank0, PKT_DONE good LEN=32 -> DESC_VALID=1, DESC_BANK=0, DESC_LEN=32, RD_ADDR 0..7 return written words 1 cycle later.
REQ-040 Three good packets without pop -> first two queued (banks 0,1), third discarded, DROP_CNT=1; after one pop, next packet lands in bank0.
REQ-041 PKT_DONE with PKT_GOOD=0, then PKT_LEN=600 good -> both dropped, DROP_CNT=2, DESC_VALID=0, bank0 still FILLING.
REQ-042 PKT_DONE and DESC_POP same cycle with both banks FULL/FILLING -> pop frees head, commit succeeds, DESC_VALID stays 1 on next bank.
REQ-043 WR_ADDR=10'h200 strobes -> buffer unchanged; RST=0 mid-packet -> all outputs 0 immediately, DROP_CNT=0.
REQ-044 Build without ETH_RX_PKTBUF_DROPCNT_EN, repeat REQ-040 -> DROP_CNT=0, delivery identical.

Source files
------------

// File: rtl/eth_rx_pktbuf_pkg.sv
// eth_rx_pktbuf_pkg: shared bank state encoding, default sizes and helpers.
package eth_rx_pktbuf_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    localparam int BANK_WORDS_DEF = 128;
    localparam int MAX_LEN_DEF    = 512;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hffff) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/eth_rx_pktbuf_ram.sv
// eth_rx_pktbuf_ram: packet storage, one write port and one registered read port, address {bank,index}.
module eth_rx_pktbuf_ram #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [7:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        re,
    input  logic [7:0]  raddr,
    output logic [31:0] rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Read data holds while re is low; only the output register is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/eth_rx_pktbuf.sv
// eth_rx_pktbuf: two-bank receive packet buffer delivering packets in arrival order.
// Define ETH_RX_PKTBUF_DROPCNT_EN to build the saturating DROP_CNT counter.
module eth_rx_pktbuf
    import eth_rx_pktbuf_pkg::*;
#(
    parameter int BANK_WORDS = BANK_WORDS_DEF,
    parameter int MAX_LEN    = MAX_LEN_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [9:0]  WR_ADDR,
    input  logic [31:0] WR_DATA,
    input  logic        WR_STROBE,
    input  logic        PKT_DONE,
    input  logic        PKT_GOOD,
    input  logic [15:0] PKT_LEN,
    output logic        DESC_VALID,
    output logic        DESC_BANK,
    output logic [15:0] DESC_LEN,
    input  logic        DESC_POP,
    input  logic        RD_EN,
    input  logic [6:0]  RD_ADDR,
    output logic [31:0] RD_DATA,
    output logic [15:0] DROP_CNT
);

    bank_state_t st [2];
    bank_state_t st_n [2];
    logic [15:0] len [2];
    logic        wr_bank, rd_bank, drop_flag;
    logic        wr_bank_n, rd_bank_n, drop_flag_n;
    logic        pop, wr_hit, wr_miss, commit, drop_pkt;
    logic        unused_addr;

    assign unused_addr = ^WR_ADDR[8:7];

    // Pop is applied first so a freed bank can accept this cycle's write and commit.
    always_comb begin
        st_n      = st;
        rd_bank_n = rd_bank;
        wr_bank_n = wr_bank;
        pop       = DESC_POP && st[rd_bank] == FULL;
        if (pop) begin
            st_n[rd_bank] = (rd_bank == wr_bank) ? FILLING : FREE;
            rd_bank_n     = ~rd_bank;
        end
        wr_hit   = WR_STROBE && !WR_ADDR[9] && st_n[wr_bank] == FILLING;
        wr_miss  = WR_STROBE && !WR_ADDR[9] && st_n[wr_bank] != FILLING;
        commit   = PKT_DONE && PKT_GOOD && PKT_LEN <= 16'(MAX_LEN) && !drop_flag
                   && st_n[wr_bank] == FILLING;
        drop_pkt = PKT_DONE && !commit;
        if (commit) begin
            st_n[wr_bank]  = FULL;
            st_n[~wr_bank] = (st_n[~wr_bank] == FREE) ? FILLING : st_n[~wr_bank];
            wr_bank_n      = ~wr_bank;
        end
        drop_flag_n = PKT_DONE ? 1'b0 : (drop_flag || wr_miss);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            st[0]     <= FILLING;
            st[1]     <= FREE;
            len[0]    <= '0;
            len[1]    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            drop_flag <= 1'b0;
        end else begin
            st        <= st_n;
            wr_bank   <= wr_bank_n;
            rd_bank   <= rd_bank_n;
            drop_flag <= drop_flag_n;
            if (commit)
                len[wr_bank] <= PKT_LEN;
        end
    end

    assign DESC_VALID = st[rd_bank] == FULL;
    assign DESC_BANK  = rd_bank;
    assign DESC_LEN   = len[rd_bank];

`ifdef ETH_RX_PKTBUF_DROPCNT_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            drop_cnt <= '0;
        else if (drop_pkt)
            drop_cnt <= sat_inc(drop_cnt);
    end

    assign DROP_CNT = drop_cnt;
`else
    logic unused_drop;

    assign unused_drop = drop_pkt;
    assign DROP_CNT    = '0;
`endif

    eth_rx_pktbuf_ram #(
        .DEPTH(2 * BANK_WORDS)
    ) u_ram (
        .clk  (CLK),
        .rst_n(RST),
        .we   (wr_hit),
        .waddr({wr_bank, WR_ADDR[6:0]}),
        .wdata(WR_DATA),
        .re   (RD_EN),
        .raddr({rd_bank, RD_ADDR}),
        .rdata(RD_DATA)
    );

endmodule
